// File: rtl/onn_pkg.sv
// Shared constants, status codes and state encoding for the phase result capture path.
// Build option PHASE_PARITY_EN appends an even-parity bit to the serial frame.
package onn_pkg;

  localparam int N_NEURON = 15;
  localparam int PHASE_W  = 4;
  localparam int PHI_W    = N_NEURON * PHASE_W;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_CONV  = 2'b01;
  localparam logic [1:0] ST_TOUT  = 2'b10;
  localparam logic [1:0] ST_INCON = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SEND  = 2'd2
  } state_e;

`ifdef PHASE_PARITY_EN
  localparam int FRAME_W = PHI_W + 3;

  function automatic logic even_parity(input logic [PHI_W+1:0] v);
    return ^v;
  endfunction
`else
  localparam int FRAME_W = PHI_W + 2;
`endif

  localparam int FCNT_W = $clog2(FRAME_W);

endpackage

// File: rtl/phase_result_capture_if.sv
// Serial readout channel: one frame bit per accepted valid/ready beat.
interface phase_result_capture_if;
  logic ser_out;
  logic ser_valid;
  logic ser_last;
  logic ser_ready;

  modport master (output ser_out, output ser_valid, output ser_last, input ser_ready);
  modport slave  (input ser_out, input ser_valid, input ser_last, output ser_ready);
endinterface

// File: rtl/phase_result_capture_frame_shifter.sv
// Parallel-load PISO that streams a captured frame MSB first, advancing only on accepted beats.
module frame_shifter
  import onn_pkg::*;
(
  input  logic                 clk,
  input  logic                 re,
  input  logic                 load_i,
  input  logic [FRAME_W-1:0]   frame_i,
  phase_result_capture_if.master ser,
  output logic                 last_acc_o,
  output logic                 done_o
);

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [FCNT_W-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               accept_s;

  assign accept_s   = valid_q & ser.ser_ready;
  assign last_acc_o = accept_s & last_q;

  // Load, shift-on-accept and end-of-frame sequencing.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    if (load_i) begin
      shreg_d = frame_i;
      cnt_d   = {FCNT_W{1'b0}};
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (accept_s && last_q) begin
      shreg_d = {FRAME_W{1'b0}};
      cnt_d   = {FCNT_W{1'b0}};
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b1;
    end else if (accept_s) begin
      shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      cnt_d   = cnt_q + FCNT_W'(1);
      last_d  = (cnt_q == FCNT_W'(FRAME_W - 2));
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      shreg_q <= {FRAME_W{1'b0}};
      cnt_q   <= {FCNT_W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign ser.ser_out   = shreg_q[FRAME_W-1];
  assign ser.ser_valid = valid_q;
  assign ser.ser_last  = last_q;
  assign done_o        = done_q;

endmodule

// File: rtl/phase_result_capture.sv
// Detects end of a network run (inconsistent / converged / timed out), snapshots the phases
// and streams a status-tagged frame. Build option PHASE_PARITY_EN adds a trailing parity bit.
module phase_result_capture
  import onn_pkg::*;
#(
  parameter int STABLE_CNT = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic               clk,
  input  logic               re,
  input  logic               start,
  input  logic               steady_cheak,
  input  logic               inconsistant_cheak,
  // Upstream phi_out[0:59] connects positionally: its element 0 (neuron 0 MSB) is bit PHI_W-1 here.
  input  logic [PHI_W-1:0]   phi_in,
  phase_result_capture_if.master ser,
  output logic [1:0]         status,
  output logic               busy,
  output logic               done
);

  localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CNT);
  localparam logic [15:0] TOUT_LIM   = 16'(TIMEOUT);

  state_e             state_q, state_d;
  logic [7:0]         stable_q, stable_d, stable_inc_s, stable_nxt_s;
  logic [15:0]        tout_q, tout_d, tout_inc_s;
  logic [1:0]         status_q, status_d;
  logic               busy_q, busy_d;
  logic               capture_s;
  logic [1:0]         code_s;
  logic [FRAME_W-1:0] frame_s;
  logic               last_acc_s;

  // Exit-condition decode and counter/status next values.
  always_comb begin
    stable_inc_s = (stable_q == 8'hFF)    ? 8'hFF    : stable_q + 8'd1;
    tout_inc_s   = (tout_q   == 16'hFFFF) ? 16'hFFFF : tout_q + 16'd1;
    stable_nxt_s = steady_cheak ? stable_inc_s : 8'd0;
    capture_s    = 1'b0;
    code_s       = ST_NONE;
    stable_d     = stable_q;
    tout_d       = tout_q;
    status_d     = status_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          stable_d = 8'd0;
          tout_d   = 16'd0;
        end else begin
          stable_d = stable_q;
        end
      end
      ARMED: begin
        if (start) begin
          stable_d = 8'd0;
          tout_d   = 16'd0;
        end else begin
          stable_d = stable_nxt_s;
          tout_d   = tout_inc_s;
          // Priority: inconsistent beats convergence beats timeout.
          if (inconsistant_cheak) begin
            capture_s = 1'b1;
            code_s    = ST_INCON;
          end else if (stable_nxt_s >= STABLE_LIM) begin
            capture_s = 1'b1;
            code_s    = ST_CONV;
          end else if (tout_inc_s >= TOUT_LIM) begin
            capture_s = 1'b1;
            code_s    = ST_TOUT;
          end else begin
            capture_s = 1'b0;
          end
          if (capture_s) begin
            status_d = code_s;
          end else begin
            status_d = status_q;
          end
        end
      end
      SEND: begin
        stable_d = stable_q;
      end
      default: begin
        stable_d = stable_q;
      end
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARMED;
        else       state_d = IDLE;
      end
      ARMED: begin
        if (start)          state_d = ARMED;
        else if (capture_s) state_d = SEND;
        else                state_d = ARMED;
      end
      SEND: begin
        if (last_acc_s) state_d = IDLE;
        else            state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    busy_d = 1'b0;
    if (state_d != IDLE) busy_d = 1'b1;
    else                 busy_d = 1'b0;
  end

  // FSM state and registered busy.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Run counters and last result.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      stable_q <= 8'd0;
      tout_q   <= 16'd0;
      status_q <= ST_NONE;
    end else begin
      stable_q <= stable_d;
      tout_q   <= tout_d;
      status_q <= status_d;
    end
  end

`ifdef PHASE_PARITY_EN
  assign frame_s = {code_s, phi_in, even_parity({code_s, phi_in})};
`else
  assign frame_s = {code_s, phi_in};
`endif

  frame_shifter u_shifter (
    .clk        (clk),
    .re         (re),
    .load_i     (capture_s),
    .frame_i    (frame_s),
    .ser        (ser),
    .last_acc_o (last_acc_s),
    .done_o     (done)
  );

  assign status = status_q;
  assign busy   = busy_q;

endmodule
